// File: rtl/mem_stage_pkg.sv
// Purpose: shared encodings and FSM state type for the memory stage.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
// Contents: size encodings, load/store encodings, FSM state typedef, and a
// size normaliser that folds the reserved size code onto word.
package mem_stage_pkg;

    localparam logic [1:0] MEM_SZ_BYTE = 2'b00;
    localparam logic [1:0] MEM_SZ_HALF = 2'b01;
    localparam logic [1:0] MEM_SZ_WORD = 2'b11;

    localparam logic MEM_LOAD  = 1'b0;
    localparam logic MEM_STORE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Size code 2'b10 is reserved and behaves exactly like a word access.
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'b10) ? MEM_SZ_WORD : sz;
    endfunction

endpackage

// File: rtl/load_aligner.sv
// Purpose: pick the addressed byte/half lane from a memory word and extend it.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
// Ports: rdata (raw memory word), size (normalised size code), unsign
// (1 = zero-extend, 0 = sign-extend), offset (byte offset in word), data (result).
module load_aligner
    import mem_stage_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic [NBITS-1:0] rdata,
    input  logic [1:0]       size,
    input  logic             unsign,
    input  logic [1:0]       offset,
    output logic [NBITS-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (offset)
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            2'd3:    lane_b = rdata[31:24];
            default: lane_b = rdata[7:0];
        endcase
        // Half accesses are always half-aligned here, so offset[1] picks the lane.
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        data = rdata;
        case (size)
            MEM_SZ_BYTE: data = {{(NBITS-8){~unsign & lane_b[7]}}, lane_b};
            MEM_SZ_HALF: data = {{(NBITS-16){~unsign & lane_h[15]}}, lane_h};
            default:     data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Purpose: pipeline memory stage; turns one load/store into one memory request.
// Latency: 3 cycles minimum (detect, request w/ ack, done) plus 1 per ack wait cycle.
// Backpressure: o_stall holds upstream from detect until the ack cycle inclusive.
// Ports: i_clk/i_rst (sync active-high), i_flg_* + i_eff_addr + i_st_data from
// upstream, o_mem_*/i_mem_* memory port, o_stall/o_ld_data/o_ld_valid/o_misaligned
// back to the pipeline. Optional macro MEM_STAGE_ALIGN_CHECK_EN flags misaligned
// half/word accesses instead of silently aligning them.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flg_mem_op,
    input  logic             i_flg_mem_type,
    input  logic [1:0]       i_flg_mem_size,
    input  logic             i_flg_unsign,
    input  logic [NBITS-1:0] i_eff_addr,
    input  logic [NBITS-1:0] i_st_data,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic [NBITS-1:0] o_mem_addr,
    output logic [NBITS-1:0] o_mem_wdata,
    output logic [3:0]       o_mem_be,
    input  logic             i_mem_ack,
    input  logic [NBITS-1:0] i_mem_rdata,
    output logic             o_stall,
    output logic [NBITS-1:0] o_ld_data,
    output logic             o_ld_valid,
    output logic             o_misaligned
);

    state_t           state, state_nxt;
    logic [1:0]       size_n;
    logic [1:0]       off;
    logic             mis;
    logic             accept;
    logic [3:0]       be_c;
    logic [NBITS-1:0] wdata_c;
    logic [NBITS-1:0] ld_ext;

    // Request context captured in IDLE; upstream changes afterwards are ignored.
    logic             we_q;
    logic [1:0]       size_q;
    logic             unsign_q;
    logic [1:0]       off_q;

    assign size_n = norm_size(i_flg_mem_size);

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign mis = ((size_n == MEM_SZ_HALF) && i_eff_addr[0]) ||
                 ((size_n == MEM_SZ_WORD) && (i_eff_addr[1:0] != 2'b00));
`else
    assign mis = 1'b0;
`endif

    // Low address bits are forced aligned; for an accepted access with the
    // check enabled this is identical to the raw offset.
    always_comb begin
        off = i_eff_addr[1:0];
        case (size_n)
            MEM_SZ_HALF: off = {i_eff_addr[1], 1'b0};
            MEM_SZ_WORD: off = 2'b00;
            default:     off = i_eff_addr[1:0];
        endcase
    end

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = i_st_data;
        case (size_n)
            MEM_SZ_BYTE: begin
                be_c    = 4'b0001 << off;
                wdata_c = {(NBITS/8){i_st_data[7:0]}};
            end
            MEM_SZ_HALF: begin
                be_c    = 4'b0011 << off;
                wdata_c = {(NBITS/16){i_st_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = i_st_data;
            end
        endcase
    end

    assign accept = (state == ST_IDLE) && i_flg_mem_op && !mis;

    load_aligner #(.NBITS(NBITS)) u_load_aligner (
        .rdata  (i_mem_rdata),
        .size   (size_q),
        .unsign (unsign_q),
        .offset (off_q),
        .data   (ld_ext)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            we_q        <= MEM_LOAD;
            size_q      <= MEM_SZ_BYTE;
            unsign_q    <= 1'b0;
            off_q       <= 2'b00;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= 4'b0000;
            o_ld_data   <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                we_q        <= i_flg_mem_type;
                size_q      <= size_n;
                unsign_q    <= i_flg_unsign;
                off_q       <= off;
                o_mem_addr  <= {i_eff_addr[NBITS-1:2], 2'b00};
                o_mem_wdata <= wdata_c;
                o_mem_be    <= be_c;
            end
            if ((state == ST_REQ) && i_mem_ack && (we_q == MEM_LOAD)) begin
                o_ld_data <= ld_ext;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        o_mem_req    = 1'b0;
        o_stall      = 1'b0;
        o_ld_valid   = 1'b0;
        o_misaligned = 1'b0;
        case (state)
            ST_IDLE: begin
                o_misaligned = i_flg_mem_op && mis;
                if (accept) begin
                    o_stall   = 1'b1;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                o_mem_req = 1'b1;
                o_stall   = 1'b1;
                if (i_mem_ack) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                o_ld_valid = (we_q == MEM_LOAD);
                state_nxt  = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Keep pipeline-facing strobes quiet while reset is held.
        if (i_rst) begin
            o_mem_req    = 1'b0;
            o_stall      = 1'b0;
            o_ld_valid   = 1'b0;
            o_misaligned = 1'b0;
        end
    end

    // Write enable only qualifies a live request.
    assign o_mem_we = (state == ST_REQ) && we_q;

endmodule

// File: tb/tb_mem_stage.sv
// Purpose: self-checking bench for mem_stage (table of transactions plus
// hand-written reset, stray-ack and back-to-back sequences).
// Latency/backpressure: observed per transaction against hand-computed cycle counts.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        flg_mem_op;
    logic        flg_mem_type;
    logic [1:0]  flg_mem_size;
    logic        flg_unsign;
    logic [31:0] eff_addr;
    logic [31:0] st_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        stall;
    logic [31:0] ld_data;
    logic        ld_valid;
    logic        misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage #(.NBITS(32)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_flg_mem_op   (flg_mem_op),
        .i_flg_mem_type (flg_mem_type),
        .i_flg_mem_size (flg_mem_size),
        .i_flg_unsign   (flg_unsign),
        .i_eff_addr     (eff_addr),
        .i_st_data      (st_data),
        .o_mem_req      (mem_req),
        .o_mem_we       (mem_we),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_be       (mem_be),
        .i_mem_ack      (mem_ack),
        .i_mem_rdata    (mem_rdata),
        .o_stall        (stall),
        .o_ld_data      (ld_data),
        .o_ld_valid     (ld_valid),
        .o_misaligned   (misaligned)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        typ;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] st;
        logic [31:0] rdata;
        int          dly;
        logic        mis;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_ld;
        int          e_cyc;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one access starting in the next cycle; returns at the DONE cycle
    // (or right after the detect cycle for a misaligned access).
    task automatic run_vec(input vec_t v);
        int   cyc;
        int   nreq;
        logic done;
        @(negedge clk);
        flg_mem_op   = 1'b1;
        flg_mem_type = v.typ;
        flg_mem_size = v.size;
        flg_unsign   = v.uns;
        eff_addr     = v.addr;
        st_data      = v.st;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;
        #1;
        chk("detect_misaligned", misaligned, v.mis);
        chk("detect_stall", stall, !v.mis);
        chk("detect_req", mem_req, 1'b0);
        chk("detect_ld_valid", ld_valid, 1'b0);
        if (v.mis) return;
        cyc  = 1;
        nreq = 0;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            #1;
            cyc++;
            if (mem_req) begin
                chk("req_addr", mem_addr, v.e_addr);
                chk("req_be", mem_be, v.e_be);
                chk("req_wdata", mem_wdata, v.e_wdata);
                chk("req_we", mem_we, v.typ);
                chk("req_stall", stall, 1'b1);
                mem_ack   = (nreq == v.dly);
                mem_rdata = mem_ack ? v.rdata : 32'hDEAD_BEEF;
                nreq++;
                // Upstream wanders while the request is outstanding.
                eff_addr     = v.addr ^ 32'h0000_0F0F;
                st_data      = ~v.st;
                flg_mem_size = v.size ^ 2'b01;
                flg_mem_type = ~v.typ;
                flg_unsign   = ~v.uns;
            end else begin
                mem_ack = 1'b0;
                done    = 1'b1;
                chk("done_stall", stall, 1'b0);
                chk("done_ld_valid", ld_valid, !v.typ);
                chk("done_misaligned", misaligned, 1'b0);
                if (!v.typ) chk("done_ld_data", ld_data, v.e_ld);
            end
        end
        chk("done_reached", done, 1'b1);
        chk("latency", cyc, v.e_cyc);
    endtask

    task automatic go_idle_check();
        @(negedge clk);
        flg_mem_op = 1'b0;
        mem_ack    = 1'b0;
        #1;
        chk("after_ld_valid", ld_valid, 1'b0);
        chk("after_req", mem_req, 1'b0);
        chk("after_stall", stall, 1'b0);
    endtask

    initial begin
        //        typ   size   uns   addr          st            rdata         dly mis   e_addr        e_be     e_wdata       e_ld          cyc
        vt[0]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 0, 1'b0, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80, 3};
        vt[1]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 32'h0,        4, 1'b0, 32'h0000_0200, 4'b1100, 32'hABCD_ABCD, 32'h0,        7};
        vt[2]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h1234_56A5, 32'h0,        1, 1'b0, 32'h0000_0010, 4'b0010, 32'hA5A5_A5A5, 32'h0,        4};
        vt[3]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0042, 32'h0,        32'h8001_7FFF, 0, 1'b0, 32'h0000_0040, 4'b1100, 32'h0,        32'h0000_8001, 3};
        vt[4]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0040, 32'h0,        32'h1234_F00D, 2, 1'b0, 32'h0000_0040, 4'b0011, 32'h0,        32'hFFFF_F00D, 5};
        vt[5]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0001, 32'h0,        32'h0000_9A00, 0, 1'b0, 32'h0000_0000, 4'b0010, 32'h0,        32'h0000_009A, 3};
        vt[6]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 0, 1'b0, 32'h0000_0300, 4'b1111, 32'h0,        32'hCAFE_F00D, 3};
        vt[7]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0008, 32'h1122_3344, 32'h0,        0, 1'b0, 32'h0000_0008, 4'b1111, 32'h1122_3344, 32'h0,        3};
        vt[10] = '{1'b0, 2'b00, 1'b0, 32'h0000_0102, 32'h0,        32'h007F_0000, 0, 1'b0, 32'h0000_0100, 4'b0100, 32'h0,        32'h0000_007F, 3};
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        vt[8]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0101, 32'h0,        32'h8765_4321, 0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        0};
        vt[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_5A5A, 32'h0,        0, 1'b1, 32'h0,        4'b0000, 32'h0,        32'h0,        0};
`else
        vt[8]  = '{1'b0, 2'b11, 1'b0, 32'h0000_0101, 32'h0,        32'h8765_4321, 0, 1'b0, 32'h0000_0100, 4'b1111, 32'h0,        32'h8765_4321, 3};
        vt[9]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0203, 32'h0000_5A5A, 32'h0,        0, 1'b0, 32'h0000_0200, 4'b1100, 32'h5A5A_5A5A, 32'h0,        3};
`endif

        rst          = 1'b1;
        flg_mem_op   = 1'b0;
        flg_mem_type = 1'b0;
        flg_mem_size = 2'b00;
        flg_unsign   = 1'b0;
        eff_addr     = 32'h0;
        st_data      = 32'h0;
        mem_ack      = 1'b0;
        mem_rdata    = 32'h0;

        // Reset state.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", mem_req, 1'b0);
        chk("rst_we", mem_we, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ld_valid", ld_valid, 1'b0);
        chk("rst_misaligned", misaligned, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_be", mem_be, 4'b0000);
        @(negedge clk);
        rst = 1'b0;

        // Stray acks while idle are ignored.
        @(negedge clk);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1234_5678;
        repeat (2) begin
            @(negedge clk);
            #1;
            chk("stray_ack_req", mem_req, 1'b0);
            chk("stray_ack_ld_valid", ld_valid, 1'b0);
            chk("stray_ack_stall", stall, 1'b0);
        end
        mem_ack = 1'b0;

        // Table of single transactions.
        for (int i = 0; i < 11; i++) begin
            run_vec(vt[i]);
            go_idle_check();
        end

        // Back-to-back load then store: DONE of the load is immediately followed
        // by the store's detect cycle.
        run_vec(vt[0]);
        run_vec(vt[7]);
        go_idle_check();

        // Reset while a request is outstanding, ack arrives one cycle late.
        @(negedge clk);
        flg_mem_op   = 1'b1;
        flg_mem_type = 1'b0;
        flg_mem_size = 2'b11;
        flg_unsign   = 1'b0;
        eff_addr     = 32'h0000_0440;
        #1;
        chk("rstreq_detect_stall", stall, 1'b1);
        @(negedge clk);
        #1;
        chk("rstreq_in_req", mem_req, 1'b1);
        rst        = 1'b1;
        flg_mem_op = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFEED_FACE;
        #1;
        chk("rstreq_req_dropped", mem_req, 1'b0);
        chk("rstreq_stall", stall, 1'b0);
        chk("rstreq_addr_cleared", mem_addr, 32'h0);
        chk("rstreq_ld_valid", ld_valid, 1'b0);
        repeat (3) begin
            @(negedge clk);
            mem_ack = 1'b0;
            #1;
            chk("rstreq_late_ld_valid", ld_valid, 1'b0);
            chk("rstreq_late_req", mem_req, 1'b0);
            chk("rstreq_late_ld_data", ld_data, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
